// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-stage bundle: redirect inputs, I-cache port and decode packet.
// The master modport is the fetch controller; slave is its environment.
interface fetch_pc_ctrl_if;
  logic        csr_new_pc_req_i;
  logic [31:0] csr_pc_new_i;
  logic        exe_new_pc_req_i;
  logic [31:0] exe_pc_new_i;
  logic        stall_i;
  logic        ic_req_o;
  logic [31:0] ic_addr_o;
  logic        ic_ack_i;
  logic [31:0] ic_data_i;
  logic        page_fault_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [1:0]  id_exc_o;

  modport master (
    input  csr_new_pc_req_i, csr_pc_new_i, exe_new_pc_req_i, exe_pc_new_i,
    input  stall_i, ic_ack_i, ic_data_i, page_fault_i,
    output ic_req_o, ic_addr_o, id_valid_o, id_instr_o, id_pc_o, id_exc_o
  );

  modport slave (
    output csr_new_pc_req_i, csr_pc_new_i, exe_new_pc_req_i, exe_pc_new_i,
    output stall_i, ic_ack_i, ic_data_i, page_fault_i,
    input  ic_req_o, ic_addr_o, id_valid_o, id_instr_o, id_pc_o, id_exc_o
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: one outstanding I-cache request, CSR/EXE redirects,
// fetch cancellation, and a one-entry skid buffer in front of decode.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  fetch_pc_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, KILL, TRAP} state_t;

  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_ALIGN = 2'b01;
  localparam logic [1:0] EXC_PF    = 2'b10;

  state_t      state, state_n;
  logic [31:0] pc_ff, pc_n;
  logic [31:0] kill_addr, kill_addr_n;

  logic        out_valid, skid_valid;
  logic [31:0] out_instr, out_pc, skid_instr, skid_pc;
  logic [1:0]  out_exc, skid_exc;

  logic        redir, req, ack, restart, emit;
  logic [31:0] target, emit_instr, emit_pc;
  logic [1:0]  emit_exc;

  assign redir  = bus.csr_new_pc_req_i | bus.exe_new_pc_req_i;
  assign target = bus.csr_new_pc_req_i ? bus.csr_pc_new_i : bus.exe_pc_new_i;

  // KILL keeps the old request up until its ack; REQ launches only with room in the skid.
  assign req = (state == KILL) || ((state == REQ) && !skid_valid);
  assign ack = bus.ic_ack_i && req;

  assign bus.ic_req_o   = req;
  assign bus.ic_addr_o  = (state == KILL) ? kill_addr : pc_ff;
  assign bus.id_valid_o = out_valid;
  assign bus.id_instr_o = out_instr;
  assign bus.id_pc_o    = out_pc;
  assign bus.id_exc_o   = out_exc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc_ff     <= RESET_PC;
      kill_addr <= RESET_PC;
    end else begin
      state     <= state_n;
      pc_ff     <= pc_n;
      kill_addr <= kill_addr_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = redir ? target : pc_ff;
    kill_addr_n = kill_addr;
    restart     = 1'b0;
    emit        = 1'b0;
    emit_instr  = NOP_INSTR;
    emit_pc     = pc_ff;
    emit_exc    = EXC_NONE;
    case (state)
      IDLE: restart = 1'b1;
      REQ: begin
        if (redir) begin
          if (req && !ack) begin
            state_n     = KILL;
            kill_addr_n = pc_ff;
          end else begin
            restart = 1'b1;
          end
        end else if (ack) begin
          emit = 1'b1;
          if (bus.page_fault_i) begin
            emit_exc = EXC_PF;
            state_n  = TRAP;
          end else begin
            emit_instr = bus.ic_data_i;
            pc_n       = pc_ff + 32'd4;
          end
        end
      end
      KILL: restart = ack;
      TRAP: restart = redir;
      default: state_n = IDLE;
    endcase
    // A misaligned fetch target never reaches the cache; it traps immediately.
    if (restart) begin
      if (pc_n[1:0] != 2'b00) begin
        state_n  = TRAP;
        emit     = 1'b1;
        emit_pc  = pc_n;
        emit_exc = EXC_ALIGN;
      end else begin
        state_n = REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_instr  <= NOP_INSTR;
      out_pc     <= 32'd0;
      out_exc    <= EXC_NONE;
      skid_valid <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= 32'd0;
      skid_exc   <= EXC_NONE;
    end else if (redir) begin
      skid_valid <= 1'b0;
      out_valid  <= emit;
      if (emit) begin
        out_instr <= emit_instr;
        out_pc    <= emit_pc;
        out_exc   <= emit_exc;
      end
    end else if (emit) begin
      if (out_valid && bus.stall_i) begin
        skid_valid <= 1'b1;
        skid_instr <= emit_instr;
        skid_pc    <= emit_pc;
        skid_exc   <= emit_exc;
      end else begin
        out_valid <= 1'b1;
        out_instr <= emit_instr;
        out_pc    <= emit_pc;
        out_exc   <= emit_exc;
      end
    end else if (!bus.stall_i) begin
      if (skid_valid) begin
        skid_valid <= 1'b0;
        out_valid  <= 1'b1;
        out_instr  <= skid_instr;
        out_pc     <= skid_pc;
        out_exc    <= skid_exc;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: the driver plays cache and pipeline,
// a transaction-level model queues expected packets, a monitor pops them.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  exc;
  } pkt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_pc_ctrl_if bus ();

  fetch_pc_ctrl #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pkt_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_pc, m_kill_addr;
  bit          m_idle, m_trap, m_kill;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model view: at most two packets buffered toward decode, fetch pauses when both are taken.
  task automatic model_restart();
    if (m_pc[1:0] != 2'b00) begin
      exp_q.push_back('{NOP_INSTR, m_pc, 2'b01});
      m_trap = 1'b1;
    end else begin
      m_trap = 1'b0;
    end
  endtask

  task automatic drive_idle();
    bus.csr_new_pc_req_i = 1'b0;
    bus.csr_pc_new_i     = 32'd0;
    bus.exe_new_pc_req_i = 1'b0;
    bus.exe_pc_new_i     = 32'd0;
    bus.stall_i          = 1'b0;
    bus.ic_ack_i         = 1'b0;
    bus.ic_data_i        = 32'd0;
    bus.page_fault_i     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_ic_req",   64'(bus.ic_req_o),   64'd0);
    check_output("rst_ic_addr",  64'(bus.ic_addr_o),  64'(RESET_PC));
    check_output("rst_id_valid", 64'(bus.id_valid_o), 64'd0);
    check_output("rst_id_instr", 64'(bus.id_instr_o), 64'(NOP_INSTR));
    check_output("rst_id_pc",    64'(bus.id_pc_o),    64'd0);
    check_output("rst_id_exc",   64'(bus.id_exc_o),   64'd0);
    exp_q.delete();
    m_pc   = RESET_PC;
    m_idle = 1'b1;
    m_trap = 1'b0;
    m_kill = 1'b0;
    rst    = 1'b0;
  endtask

  // One clock of stimulus starting just after a rising edge, then the model step for it.
  task automatic apply_stimulus(input bit csr_r, input logic [31:0] csr_t,
                                input bit exe_r, input logic [31:0] exe_t,
                                input bit st, input bit ack_en, input bit pf);
    bit          exp_req, m_ack, redir;
    logic [31:0] tgt, data;
    exp_req = !m_idle && !m_trap && (m_kill || exp_q.size() < 2);
    check_output("ic_req", 64'(bus.ic_req_o), 64'(exp_req));
    if (exp_req)
      check_output("ic_addr", 64'(bus.ic_addr_o), 64'(m_kill ? m_kill_addr : m_pc));
    data = $urandom;
    bus.csr_new_pc_req_i = csr_r;
    bus.csr_pc_new_i     = csr_t;
    bus.exe_new_pc_req_i = exe_r;
    bus.exe_pc_new_i     = exe_t;
    bus.stall_i          = st;
    bus.ic_ack_i         = ack_en && bus.ic_req_o;
    bus.ic_data_i        = data;
    bus.page_fault_i     = pf && ack_en && bus.ic_req_o;
    m_ack = ack_en && bus.ic_req_o && exp_req;
    @(posedge clk);
    #1;
    redir = csr_r || exe_r;
    tgt   = csr_r ? csr_t : exe_t;
    if (m_idle) begin
      m_idle = 1'b0;
      if (redir) begin
        exp_q.delete();
        m_pc = tgt;
      end
      model_restart();
    end else if (redir) begin
      exp_q.delete();
      if (exp_req && !m_ack) begin
        if (!m_kill) m_kill_addr = m_pc;
        m_kill = 1'b1;
        m_trap = 1'b0;
        m_pc   = tgt;
      end else begin
        m_kill = 1'b0;
        m_pc   = tgt;
        model_restart();
      end
    end else if (m_kill) begin
      if (m_ack) begin
        m_kill = 1'b0;
        model_restart();
      end
    end else if (m_ack) begin
      if (pf) begin
        exp_q.push_back('{NOP_INSTR, m_pc, 2'b10});
        m_trap = 1'b1;
      end else begin
        exp_q.push_back('{data, m_pc, 2'b00});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step(input bit st, input bit ack_en, input bit pf);
    apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0, st, ack_en, pf);
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return 32'h0000_0020;
      1: return 32'h0000_0040;
      2: return 32'hFFFF_FFF8;
      3: return {r[31:2], 2'b00};
      4: return r;
      default: return RESET_PC;
    endcase
  endfunction

  // Decode side: a packet is consumed in any valid cycle without stall.
  always @(negedge clk) begin
    if (!rst) begin
      check_output("id_valid", 64'(bus.id_valid_o), 64'(exp_q.size() != 0));
      if (bus.id_valid_o && !bus.stall_i && exp_q.size() != 0) begin
        pkt_t e;
        e = exp_q.pop_front();
        check_output("id_instr", 64'(bus.id_instr_o), 64'(e.instr));
        check_output("id_pc",    64'(bus.id_pc_o),    64'(e.pc));
        check_output("id_exc",   64'(bus.id_exc_o),   64'(e.exc));
      end
    end
  end

  initial begin
    drive_idle();
    do_reset();
    repeat (5) step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 32'd0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 32'd0, 1'b1, 32'h0000_0003, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h0000_0020, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 32'd0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      int r;
      if (i == 1500) do_reset();
      r = $urandom_range(0, 99);
      apply_stimulus(r < 5, pick_target(), (r >= 3) && (r < 12), pick_target(),
                     $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 65,
                     $urandom_range(0, 99) < 4);
    end

    repeat (4) step(1'b0, 1'b0, 1'b0);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
